acq_control_regs: RTL and testbench

Parametrised control-register bank for the acquisition core, sitting between the SPI register-access front end and the capture/clock logic. It decodes 7-bit register addresses and holds the acquisition control state. Channel count and divisor width are parameters. Compared with the previous fixed 16-channel bank, it adds an atomic multi-byte divisor commit, a self-timed acquisition-reset pulse, and a sticky overflow flag with optional auto-stop.

---
 rtl/acq_regs_pkg.sv | 27 ++
 rtl/led_pwm.sv | 22 ++
 rtl/acq_control_regs.sv | 121 ++++++++++++
 tb/tb_acq_control_regs.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/acq_regs_pkg.sv
// Shared register map for the acquisition control bank.
// Holds the addresses, fixed read values and STATUS/CONTROL bit positions.
package acq_regs_pkg;

  localparam logic [6:0] ADDR_VERSION = 7'h00;
  localparam logic [6:0] ADDR_STATUS  = 7'h01;
  localparam logic [6:0] ADDR_LED     = 7'h05;
  localparam logic [6:0] ADDR_MODE    = 7'h0A;
  localparam logic [6:0] ADDR_SCRATCH = 7'h0D;
  localparam logic [6:0] CHANNEL_BASE = 7'h10;
  localparam logic [6:0] DIV_BASE     = 7'h20;

  localparam logic [7:0] VERSION       = 8'h20;
  localparam logic [7:0] SCRATCH_RESET = 8'h73;
  localparam logic [7:0] STATUS_FIXED  = 8'b0010_0000;

  // STATUS read bits
  localparam int STATUS_EN_BIT   = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;

  // STATUS_CONTROL write bits
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PULSE_BIT = 1;
  localparam int CTRL_W1C_BIT   = 2;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM for the status LED; the top 8 counter bits are compared
// against the brightness, so brightness 0 keeps the LED dark.
module led_pwm #(
  parameter int PWM_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] brightness,
  output logic       led_out
);

  logic [PWM_BITS-1:0] counter;

  always_ff @(posedge clk) begin
    if (rst) counter <= '0;
    else     counter <= counter + 1'b1;
  end

  // Active-low drive: the LED lights while the PWM phase is below brightness.
  assign led_out = ~(counter[PWM_BITS-1 -: 8] < brightness);

endmodule

// File: rtl/acq_control_regs.sv
// Control-register bank for the acquisition core: address decode, atomic
// multi-byte divisor commit, self-timed acquisition reset and sticky overflow.
module acq_control_regs
  import acq_regs_pkg::*;
#(
  parameter int CHANNELS     = 16,
  parameter int DIV_WIDTH    = 8,
  parameter int RESET_CYCLES = 16,
  parameter int PWM_BITS     = 18,
  parameter int AUTO_STOP    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           reg_num,
  input  logic                 reg_write,
  input  logic [7:0]           reg_data_write,
  output logic [7:0]           reg_data_read,
  input  logic                 acq_overflow,
  output logic                 acq_enable,
  output logic                 acq_reset,
  output logic                 clock_select,
  output logic [DIV_WIDTH-1:0] clock_divisor,
  output logic [CHANNELS-1:0]  channel_enable,
  output logic                 led_out
);

  localparam int NB    = CHANNELS / 8;
  localparam int DB    = DIV_WIDTH / 8;
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES);

  logic                 acq_enable_q;
  logic                 ovf_sticky;
  logic                 rst_busy;
  logic [CNT_W-1:0]     rst_cnt;
  logic [7:0]           brightness;
  logic [7:0]           scratchpad;
  logic [DIV_WIDTH-1:0] div_shadow;
  logic [DIV_WIDTH-1:0] div_next;
  logic                 wr_status;

  assign wr_status  = reg_write && (reg_num == ADDR_STATUS);
  assign rst_busy   = (rst_cnt != '0);
  assign acq_reset  = rst | rst_busy;
  assign acq_enable = acq_enable_q & ~rst_busy;

  // Committed value = new top byte over the lower shadow bytes, loaded in one edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    div_next                   = div_shadow;
    div_next[DIV_WIDTH-1 -: 8] = reg_data_write;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state is small flops, so every register is reset here; nonblocking (<=) only.
    if (rst) begin
      acq_enable_q   <= 1'b0;
      ovf_sticky     <= 1'b0;
      rst_cnt        <= '0;
      brightness     <= 8'h00;
      scratchpad     <= SCRATCH_RESET;
      clock_select   <= 1'b0;
      clock_divisor  <= '0;
      div_shadow     <= '0;
      channel_enable <= '0;
    end else begin
      if (wr_status && reg_data_write[CTRL_PULSE_BIT]) rst_cnt <= RST_LOAD;
      else if (rst_busy)                                rst_cnt <= rst_cnt - 1'b1;

      if (wr_status) begin
        acq_enable_q <= reg_data_write[CTRL_EN_BIT];
        if (reg_data_write[CTRL_W1C_BIT]) ovf_sticky <= 1'b0;
      end
      // Overflow is evaluated last so it beats both W1C and an enable write.
      if (acq_overflow) begin
        ovf_sticky <= 1'b1;
        if (AUTO_STOP != 0) acq_enable_q <= 1'b0;
      end

      if (reg_write) begin
        if (reg_num == ADDR_LED)     brightness   <= reg_data_write;
        if (reg_num == ADDR_MODE)    clock_select <= reg_data_write[0];
        if (reg_num == ADDR_SCRATCH) scratchpad   <= reg_data_write;
        for (int k = 0; k < NB; k++)
          if (reg_num == CHANNEL_BASE + 7'(k)) channel_enable[8*k +: 8] <= reg_data_write;
        for (int k = 0; k < DB - 1; k++)
          if (reg_num == DIV_BASE + 7'(k)) div_shadow[8*k +: 8] <= reg_data_write;
        if (reg_num == DIV_BASE + 7'(DB - 1)) clock_divisor <= div_next;
      end
    end
  end

  always_comb begin
    reg_data_read = 8'h00;
    case (reg_num)
      ADDR_VERSION: reg_data_read = VERSION;
      ADDR_STATUS: begin
        reg_data_read                  = STATUS_FIXED;
        reg_data_read[STATUS_EN_BIT]   = acq_enable_q;
        reg_data_read[STATUS_BUSY_BIT] = rst_busy;
        reg_data_read[STATUS_OVF_BIT]  = ovf_sticky;
      end
      ADDR_LED:     reg_data_read = brightness;
      ADDR_MODE:    reg_data_read = {7'b0, clock_select};
      ADDR_SCRATCH: reg_data_read = scratchpad;
      default:      reg_data_read = 8'h00;
    endcase
    for (int k = 0; k < NB; k++)
      if (reg_num == CHANNEL_BASE + 7'(k)) reg_data_read = channel_enable[8*k +: 8];
    for (int k = 0; k < DB; k++)
      if (reg_num == DIV_BASE + 7'(k)) reg_data_read = clock_divisor[8*k +: 8];
  end

  led_pwm #(.PWM_BITS(PWM_BITS)) u_led_pwm (
    .clk       (clk),
    .rst       (rst),
    .brightness(brightness),
    .led_out   (led_out)
  );

endmodule

// File: tb/tb_acq_control_regs.sv
// Bench for acq_control_regs: a cycle-indexed register model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_acq_control_regs;

  localparam int CHANNELS     = 32;
  localparam int DIV_WIDTH    = 16;
  localparam int RESET_CYCLES = 16;
  localparam int PWM_BITS     = 10;
  localparam int AUTO_STOP    = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [6:0]           reg_num;
  logic                 reg_write;
  logic [7:0]           reg_data_write;
  logic [7:0]           reg_data_read;
  logic                 acq_overflow;
  logic                 acq_enable;
  logic                 acq_reset;
  logic                 clock_select;
  logic [DIV_WIDTH-1:0] clock_divisor;
  logic [CHANNELS-1:0]  channel_enable;
  logic                 led_out;

  int errors = 0;
  int checks = 0;

  acq_control_regs #(
    .CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH), .RESET_CYCLES(RESET_CYCLES),
    .PWM_BITS(PWM_BITS), .AUTO_STOP(AUTO_STOP)
  ) dut (
    .clk(clk), .rst(rst), .reg_num(reg_num), .reg_write(reg_write),
    .reg_data_write(reg_data_write), .reg_data_read(reg_data_read),
    .acq_overflow(acq_overflow), .acq_enable(acq_enable), .acq_reset(acq_reset),
    .clock_select(clock_select), .clock_divisor(clock_divisor),
    .channel_enable(channel_enable), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents as byte arrays, reset pulse as a cycle window.
  bit       model_valid = 1'b0;
  int       m_cyc, m_pulse_end, m_pwm_t;
  bit       m_en_q, m_ovf, m_clksel;
  bit [7:0] m_bright, m_scratch, m_shadow;
  bit [7:0] m_chan [4];
  bit [7:0] m_div  [2];

  function automatic bit m_busy();
    return m_cyc < m_pulse_end;
  endfunction

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    if (a == 7'h00) return 8'h20;
    if (a == 7'h01) return {2'b00, 2'b10, 1'b0, m_ovf, m_busy(), m_en_q};
    if (a == 7'h05) return m_bright;
    if (a == 7'h0A) return {7'b0, m_clksel};
    if (a == 7'h0D) return m_scratch;
    if (a >= 7'h10 && a < 7'h14) return m_chan[int'(a) - 16];
    if (a >= 7'h20 && a < 7'h22) return m_div[int'(a) - 32];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_pulse_end = 0; m_pwm_t = 0;
      m_en_q = 0; m_ovf = 0; m_clksel = 0;
      m_bright = 8'h00; m_scratch = 8'h73; m_shadow = 8'h00;
      for (int i = 0; i < 4; i++) m_chan[i] = 8'h00;
      for (int i = 0; i < 2; i++) m_div[i] = 8'h00;
    end else begin
      m_cyc++;
      m_pwm_t = (m_pwm_t + 1) % (1 << PWM_BITS);
      if (reg_write) begin
        if (reg_num == 7'h01) begin
          m_en_q = reg_data_write[0];
          if (reg_data_write[1]) m_pulse_end = m_cyc + RESET_CYCLES;
          if (reg_data_write[2]) m_ovf = 0;
        end else if (reg_num == 7'h05) m_bright = reg_data_write;
        else if (reg_num == 7'h0A) m_clksel = reg_data_write[0];
        else if (reg_num == 7'h0D) m_scratch = reg_data_write;
        else if (reg_num >= 7'h10 && reg_num < 7'h14) m_chan[int'(reg_num) - 16] = reg_data_write;
        else if (reg_num == 7'h20) m_shadow = reg_data_write;
        else if (reg_num == 7'h21) begin
          m_div[0] = m_shadow;
          m_div[1] = reg_data_write;
        end
      end
      if (acq_overflow) begin
        m_ovf = 1;
        if (AUTO_STOP != 0) m_en_q = 0;
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("acq_enable", 32'(acq_enable), 32'(m_en_q && !m_busy()));
      check("acq_reset", 32'(acq_reset), 32'(rst || m_busy()));
      check("clock_select", 32'(clock_select), 32'(m_clksel));
      check("clock_divisor", 32'(clock_divisor), {16'h0, m_div[1], m_div[0]});
      check("channel_enable", channel_enable, {m_chan[3], m_chan[2], m_chan[1], m_chan[0]});
      check("led_out", 32'(led_out), 32'(!(((m_pwm_t >> (PWM_BITS - 8)) & 255) < int'(m_bright))));
      check("reg_data_read", 32'(reg_data_read), 32'(exp_read(reg_num)));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    reg_num = a; reg_data_write = d; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [6:0] a, input logic [7:0] exp);
    reg_num = a; #1;
    check(name, 32'(reg_data_read), 32'(exp));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; reg_num = '0; reg_write = 1'b0; reg_data_write = '0; acq_overflow = 1'b0;
    repeat (3) step();
    check("rst_acq_reset", 32'(acq_reset), 32'h1);
    check("rst_led_out", 32'(led_out), 32'h1);
    check("rst_acq_enable", 32'(acq_enable), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_acq_reset", 32'(acq_reset), 32'h0);
    rd_check("version", 7'h00, 8'h20);
    rd_check("scratch_reset", 7'h0D, 8'h73);
    rd_check("status_reset", 7'h01, 8'h20);

    wr(7'h0D, 8'h5A); rd_check("scratch_rw", 7'h0D, 8'h5A);
    wr(7'h0A, 8'hFF); rd_check("mode_read", 7'h0A, 8'h01);
    check("clock_select_set", 32'(clock_select), 32'h1);
    wr(7'h7F, 8'hEE); rd_check("unmapped", 7'h7F, 8'h00);

    wr(7'h10, 8'h11); wr(7'h11, 8'h22); wr(7'h12, 8'h33); wr(7'h13, 8'h44);
    check("channel_mask", channel_enable, 32'h4433_2211);
    rd_check("chan_byte2", 7'h12, 8'h33);
    rd_check("chan_oob", 7'h14, 8'h00);

    wr(7'h20, 8'hCD);
    check("div_shadow_hidden", 32'(clock_divisor), 32'h0000);
    rd_check("div_read_committed", 7'h20, 8'h00);
    wr(7'h21, 8'hAB);
    check("div_commit", 32'(clock_divisor), 32'hABCD);
    rd_check("div_low_byte", 7'h20, 8'hCD);

    wr(7'h01, 8'h03);
    check("pulse_gates_enable", 32'(acq_enable), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (acq_reset) cnt++;
      step();
    end
    check("pulse_len", 32'(cnt), 32'd16);
    check("enable_after_pulse", 32'(acq_enable), 32'h1);

    wr(7'h01, 8'h03);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (acq_reset) cnt++;
      if (i == 9) wr(7'h01, 8'h03);
      else step();
    end
    check("retrigger_len", 32'(cnt), 32'd26);

    check("enable_before_ovf", 32'(acq_enable), 32'h1);
    acq_overflow = 1'b1; step(); acq_overflow = 1'b0;
    check("ovf_autostop", 32'(acq_enable), 32'h0);
    rd_check("ovf_sticky_set", 7'h01, 8'h24);
    acq_overflow = 1'b1;
    wr(7'h01, 8'h04);
    acq_overflow = 1'b0;
    rd_check("ovf_set_beats_w1c", 7'h01, 8'h24);
    wr(7'h01, 8'h04);
    rd_check("ovf_w1c", 7'h01, 8'h20);

    wr(7'h01, 8'h01);
    acq_overflow = 1'b1;
    wr(7'h01, 8'h01);
    acq_overflow = 1'b0;
    check("ovf_beats_enable_write", 32'(acq_enable), 32'h0);

    wr(7'h01, 8'h03);
    repeat (3) step();
    rst = 1'b1; step(); step();
    check("rst_mid_pulse_high", 32'(acq_reset), 32'h1);
    rst = 1'b0;
    step();
    check("rst_mid_pulse_cleared", 32'(acq_reset), 32'h0);
    check("rst_clears_divisor", 32'(clock_divisor), 32'h0);

    wr(7'h05, 8'h40);
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!led_out) cnt++;
      step();
    end
    check("led_duty", 32'(cnt), 32'd256);
    wr(7'h05, 8'h00);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!led_out) cnt++;
      step();
    end
    check("led_off_at_zero", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
